// File: rtl/btn_count_ctrl.sv
// Button command scheduler: arbitrates debounced UP/DOWN presses, applies hold-to-auto-repeat
// and owns the displayed count. Define BTN_COUNT_CTRL_SAT_EN to saturate instead of wrapping.
module btn_count_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_level,
    input  logic             up_rise,
    input  logic             dn_level,
    input  logic             dn_rise,
    output logic [WIDTH-1:0] count,
    output logic             upd,
    output logic             dir,
    output logic             rpt
);

    localparam int HOLD_CYCLES = (CLK_HZ / 1000) * HOLD_MS;
    localparam int REP_CYCLES  = (CLK_HZ / 1000) * REPEAT_MS;
    localparam int MAX_CYCLES  = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
    localparam int TW          = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD_UP,
        REP_UP,
        HOLD_DN,
        REP_DN,
        LOCK
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] next_timer;
    logic          step_req;
    logic          step_up;
    logic          step_blocked;
    logic          commit;

    // Pressing the other button while one is active always locks out, even on the release edge.
    always_comb begin
        next_state = state;
        next_timer = timer;
        step_req   = 1'b0;
        step_up    = 1'b0;
        case (state)
            IDLE: begin
                next_timer = '0;
                if (up_rise && dn_rise) begin
                    next_state = LOCK;
                end else if (up_rise) begin
                    next_state = HOLD_UP;
                    step_req   = 1'b1;
                    step_up    = 1'b1;
                end else if (dn_rise) begin
                    next_state = HOLD_DN;
                    step_req   = 1'b1;
                end
            end
            HOLD_UP, REP_UP: begin
                if (dn_rise || dn_level) begin
                    next_state = LOCK;
                    next_timer = '0;
                end else if (!up_level) begin
                    next_state = IDLE;
                    next_timer = '0;
                end else if (timer == ((state == HOLD_UP) ? HOLD_LAST : REP_LAST)) begin
                    next_state = REP_UP;
                    next_timer = '0;
                    step_req   = 1'b1;
                    step_up    = 1'b1;
                end else begin
                    next_timer = timer + 1'b1;
                end
            end
            HOLD_DN, REP_DN: begin
                if (up_rise || up_level) begin
                    next_state = LOCK;
                    next_timer = '0;
                end else if (!dn_level) begin
                    next_state = IDLE;
                    next_timer = '0;
                end else if (timer == ((state == HOLD_DN) ? HOLD_LAST : REP_LAST)) begin
                    next_state = REP_DN;
                    next_timer = '0;
                    step_req   = 1'b1;
                end else begin
                    next_timer = timer + 1'b1;
                end
            end
            LOCK: begin
                next_timer = '0;
                if (!up_level && !dn_level) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_timer = '0;
            end
        endcase
    end

`ifdef BTN_COUNT_CTRL_SAT_EN
    assign step_blocked = step_up ? (count == {WIDTH{1'b1}}) : (count == '0);
`else
    assign step_blocked = 1'b0;
`endif

    assign commit = step_req && !step_blocked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            count <= '0;
            upd   <= 1'b0;
            dir   <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            state <= next_state;
            timer <= next_timer;
            upd   <= commit;
            rpt   <= (next_state == REP_UP) || (next_state == REP_DN);
            if (commit) begin
                count <= step_up ? (count + 1'b1) : (count - 1'b1);
                dir   <= step_up;
            end
        end
    end

endmodule

// File: tb/tb_btn_count_ctrl.sv
// Randomized and directed bench for btn_count_ctrl against a press-age reference model.
module tb_btn_count_ctrl;

    localparam int CLK_HZ    = 10_000;
    localparam int HOLD_MS   = 2;
    localparam int REPEAT_MS = 1;
    localparam int WIDTH     = 4;
    localparam int HOLD_N    = 20;
    localparam int REP_N     = 10;
    localparam int MAXV      = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             up_level = 1'b0;
    logic             up_rise = 1'b0;
    logic             dn_level = 1'b0;
    logic             dn_rise = 1'b0;
    logic [WIDTH-1:0] count;
    logic             upd;
    logic             dir;
    logic             rpt;

    int n_compared = 0;
    int n_failed   = 0;

    // Reference model: which button owns the current press, how many edges it has been held.
    int m_count, m_dir, m_upd, m_rpt, m_active, m_age;
    bit m_locked;

    btn_count_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .HOLD_MS  (HOLD_MS),
        .REPEAT_MS(REPEAT_MS),
        .WIDTH    (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .up_level(up_level),
        .up_rise (up_rise),
        .dn_level(dn_level),
        .dn_rise (dn_rise),
        .count   (count),
        .upd     (upd),
        .dir     (dir),
        .rpt     (rpt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_dir    = 0;
        m_upd    = 0;
        m_rpt    = 0;
        m_active = 0;
        m_age    = 0;
        m_locked = 1'b0;
    endtask

    // A press steps at age 0, then at HOLD_N, then every REP_N edges while held.
    task automatic model_step(input bit ul, input bit ur, input bit dl, input bit dr);
        bit stepped = 1'b0;
        bit go_up   = 1'b0;
        bit own_l, oth_l, oth_r;
        if (m_locked) begin
            if (!ul && !dl) m_locked = 1'b0;
        end else if (m_active == 0) begin
            if (ur && dr) begin
                m_locked = 1'b1;
            end else if (ur) begin
                m_active = 1; m_age = 0; stepped = 1'b1; go_up = 1'b1;
            end else if (dr) begin
                m_active = 2; m_age = 0; stepped = 1'b1;
            end
        end else begin
            own_l = (m_active == 1) ? ul : dl;
            oth_l = (m_active == 1) ? dl : ul;
            oth_r = (m_active == 1) ? dr : ur;
            if (oth_l || oth_r) begin
                m_locked = 1'b1;
                m_active = 0;
            end else if (!own_l) begin
                m_active = 0;
            end else begin
                m_age++;
                if (m_age >= HOLD_N && ((m_age - HOLD_N) % REP_N) == 0) begin
                    stepped = 1'b1;
                    go_up   = (m_active == 1);
                end
            end
        end
        m_upd = 0;
        if (stepped) begin
`ifdef BTN_COUNT_CTRL_SAT_EN
            if (!(go_up && m_count == MAXV) && !(!go_up && m_count == 0)) begin
                m_count = go_up ? m_count + 1 : m_count - 1;
                m_dir   = go_up;
                m_upd   = 1;
            end
`else
            m_count = go_up ? (m_count + 1) % (MAXV + 1) : (m_count + MAXV) % (MAXV + 1);
            m_dir   = go_up;
            m_upd   = 1;
`endif
        end
        m_rpt = (m_active != 0 && m_age >= HOLD_N) ? 1 : 0;
    endtask

    task automatic applyStimulus(input bit ul, input bit ur, input bit dl, input bit dr);
        up_level = ul;
        up_rise  = ur;
        dn_level = dl;
        dn_rise  = dr;
        @(posedge clk);
        model_step(ul, ur, dl, dr);
        #1;
        checkOutput("count", int'(count), m_count);
        checkOutput("upd", int'(upd), m_upd);
        checkOutput("dir", int'(dir), m_dir);
        checkOutput("rpt", int'(rpt), m_rpt);
    endtask

    task automatic do_reset();
        up_level = 1'b0; up_rise = 1'b0; dn_level = 1'b0; dn_rise = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_upd", int'(upd), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tap(input bit is_up, input int held);
        applyStimulus(is_up, is_up, !is_up, !is_up);
        repeat (held - 1) applyStimulus(is_up, 1'b0, !is_up, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    bit up_lv, dn_lv, up_prev, dn_prev;
    int up_left, dn_left;

    initial begin
        model_reset();
        #2;
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_dir", int'(dir), 0);
        checkOutput("rst_rpt", int'(rpt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single tap, then a 55-cycle hold giving five steps.
        tap(1'b1, 5);
        checkOutput("tap_count", int'(count), 1);
        tap(1'b1, 55);
        checkOutput("hold_count", int'(count), 6);

        // Walk to full scale and step past it in both directions.
        do_reset();
        for (int i = 0; i < MAXV; i++) tap(1'b1, 2);
        checkOutput("full_count", int'(count), MAXV);
        tap(1'b1, 2);
`ifdef BTN_COUNT_CTRL_SAT_EN
        checkOutput("sat_up", int'(count), MAXV);
`else
        checkOutput("wrap_up", int'(count), 0);
`endif
        do_reset();
        tap(1'b0, 2);
`ifdef BTN_COUNT_CTRL_SAT_EN
        checkOutput("sat_dn", int'(count), 0);
`else
        checkOutput("wrap_dn", int'(count), MAXV);
`endif

        // Simultaneous press locks until both are released.
        do_reset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (30) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lock_count", int'(count), 0);
        tap(1'b1, 3);

        // Other button arriving mid-hold locks out further steps.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (40) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("lock_hold", int'(count), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during down auto-repeat, then keep DOWN held through release.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (25) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rep_dn_rpt", int'(rpt), 1);
        rst_n = 1'b0;
        #2;
        model_reset();
        checkOutput("async_count", int'(count), 0);
        checkOutput("async_upd", int'(upd), 0);
        checkOutput("async_rpt", int'(rpt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tap(1'b0, 2);

        // Random debounced-style button traffic.
        up_lv = 1'b0; dn_lv = 1'b0; up_left = 3; dn_left = 7;
        for (int c = 0; c < 3000; c++) begin
            up_prev = up_lv;
            dn_prev = dn_lv;
            if (up_left == 0) begin
                up_lv   = ~up_lv;
                up_left = up_lv ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                                              : int'($urandom_range(1, 8)))
                                : int'($urandom_range(1, 40));
            end
            if (dn_left == 0) begin
                dn_lv   = ~dn_lv;
                dn_left = dn_lv ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                                              : int'($urandom_range(1, 8)))
                                : int'($urandom_range(1, 40));
            end
            up_left--;
            dn_left--;
            applyStimulus(up_lv, up_lv && !up_prev, dn_lv, dn_lv && !dn_prev);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/btn_count_ctrl.md
Name: btn_count_ctrl

Overview:
- Command scheduler between two debounced buttons (UP, DOWN) and the displayed binary count register.
- Sits downstream of two button debouncers; consumes their level and rise outputs.
- Arbitrates between the two buttons and applies hold-to-auto-repeat.
- Owns the count value and an update strobe consumed by the OLED display driver.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- HOLD_MS, 500, press duration before auto-repeat begins, in ms.
- REPEAT_MS, 100, auto-repeat step interval, in ms.
- WIDTH, 8, count width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- up_level  in  1  debounced UP level; 1 = pressed.
- up_rise  in  1  1-cycle UP press pulse.
- dn_level  in  1  debounced DOWN level; 1 = pressed.
- dn_rise  in  1  1-cycle DOWN press pulse.
- count  out  WIDTH  current count value.
- upd  out  1  1-cycle pulse in the cycle after count changes.
- dir  out  1  direction of last step; 1 = up, 0 = down.
- rpt  out  1  high while in an auto-repeat state.

Behaviour:
- Derived constants:
  - HOLD_CYCLES = (CLK_HZ/1000)*HOLD_MS.
  - REP_CYCLES = (CLK_HZ/1000)*REPEAT_MS.
  - Timer width = $clog2 of the larger constant, minimum 1.
- Reset (async assert; deassert is synchronous to clk): count=0, upd=0, dir=0, rpt=0, state=IDLE, timer=0.
- All outputs are registered. A step is taken at edge E; count/dir change at E; upd is high for the cycle E..E+1.
- States: IDLE, HOLD_UP, REP_UP, HOLD_DN, REP_DN, LOCK.
- IDLE:
  - up_rise & dn_rise on the same edge -> LOCK, no step.
  - up_rise only -> step up, HOLD_UP, timer=0.
  - dn_rise only -> step down, HOLD_DN, timer=0.
  - A level high without a rise never steps. This covers a button held through reset.
- HOLD_x, up side (DOWN side is symmetric):
  - Each edge with up_level=1, timer increments.
  - When timer reaches HOLD_CYCLES-1 -> step up, REP_UP, timer=0.
  - up_level=0 -> IDLE, timer=0, no step.
  - dn_rise or dn_level=1 -> LOCK, no step.
- REP_x: same as HOLD_x, but uses REP_CYCLES-1 and stays in REP_x after each step. rpt=1 only in REP_UP or REP_DN.
- LOCK: no steps. Exits to IDLE on the first edge where up_level=0 and dn_level=0.
- Arithmetic (default): modulo 2^WIDTH.
  - Up from 2^WIDTH-1 -> 0.
  - Down from 0 -> 2^WIDTH-1.
  - Each wrap still pulses upd.
- Priority when release and other-button press occur on the same edge: LOCK wins over IDLE.
- Reset mid-operation: immediately returns all state to reset values; any pending repeat is abandoned.
- rise inputs seen outside IDLE: ignored, except the LOCK transitions above.

Optional Feature:
- Macro: BTN_COUNT_CTRL_SAT_EN.
- Defined: count saturates.
  - Up at 2^WIDTH-1 or down at 0 leaves count unchanged.
  - upd stays 0 and dir is not updated.
  - The state machine and timers proceed exactly as normal.
- Undefined: modulo wrap as in Behaviour.

Test Plan:
- Common parameters: CLK_HZ=10_000, HOLD_MS=2, REPEAT_MS=1, WIDTH=4. This gives HOLD_CYCLES=20 and REP_CYCLES=10.
- Single tap: up_rise, up_level held for 5 cycles, then released -> count 0->1, exactly one upd, dir=1, rpt never high, state back to IDLE.
- Hold-repeat: up_level held 55 cycles after up_rise -> steps at rise, rise+20, rise+30, rise+40, rise+50. count=5, rpt=1 from rise+20 until release.
- Wrap (macro undefined): count=15, up tap -> count=0 with upd=1. Then down tap -> count=15 with upd=1, dir=0.
- Saturation (macro defined): count=15, up tap -> count stays 15, upd=0. count=0, down tap -> stays 0.
- Arbitration:
  - up_rise and dn_rise on the same edge -> no step, LOCK until both levels are low.
  - HOLD_UP, then dn_level rises at cycle 10 -> LOCK, no further steps even after 30 more cycles.
- Reset mid-repeat: assert rst_n=0 during REP_DN -> count=0, upd=0, rpt=0 asynchronously. Release reset with dn_level still 1 -> no step until a new dn_rise.
